// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between an instruction-fetch
// requester and a data (load/store) requester. Data normally wins, but after
// STARVE_LIMIT back-to-back data grants with a fetch waiting, the fetch wins.
// All outputs are registered; each access completes with a one-cycle ready pulse.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req, if_addr               fetch request / byte address
//   if_rdata, if_ready            fetched word / completion pulse
//   d_req, d_we, d_byte           data request, store select, byte access
//   d_signextend, d_addr, d_wdata byte-load extension, byte address, store data
//   d_rdata, d_ready              aligned/extended load result / completion pulse
//   mem_en, mem_be, mem_addr,     memory strobe, byte write enables (0 = read),
//   mem_wdata                     word address, write data
//   mem_rdata, mem_ack            memory read word / completion
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic        d_signextend,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

    state_t      state_q, state_d;
    logic [2:0]  streak_q, streak_d;
    logic        byte_q, byte_d;
    logic        sext_q, sext_d;
    logic [1:0]  lane_q, lane_d;

    logic        mem_en_d;
    logic [3:0]  mem_be_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic        if_ready_d, d_ready_d;
    logic [31:0] if_rdata_d, d_rdata_d;

    logic        grant_d, grant_if;
    logic [7:0]  lane_byte;
    logic [31:0] load_data;

    // Data wins unless a fetch is waiting and the data streak has hit the limit.
    assign grant_d  = d_req && (!if_req || (32'(streak_q) < STARVE_LIMIT));
    assign grant_if = if_req && !grant_d;

    always_comb begin
        lane_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        if (byte_q) begin
            load_data = {{24{sext_q & lane_byte[7]}}, lane_byte};
        end else begin
            load_data = mem_rdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        byte_d      = byte_q;
        sext_d      = sext_q;
        lane_d      = lane_q;
        mem_en_d    = mem_en;
        mem_be_d    = mem_be;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;

        unique case (state_q)
            IDLE: begin
                // The ready-pulse cycle makes no grant so requesters can drop.
                if (!if_ready && !d_ready) begin
                    if (grant_d) begin
                        state_d    = D_BUSY;
                        mem_en_d   = 1'b1;
                        mem_addr_d = {d_addr[31:2], 2'b00};
                        lane_d     = d_addr[1:0];
                        byte_d     = d_byte;
                        sext_d     = d_signextend;
                        if (!d_we) begin
                            mem_be_d = 4'h0;
                        end else if (d_byte) begin
                            mem_be_d = 4'b0001 << d_addr[1:0];
                        end else begin
                            mem_be_d = 4'hF;
                        end
                        mem_wdata_d = d_byte ? {4{d_wdata[7:0]}} : d_wdata;
                        if (if_req) begin
                            streak_d = (streak_q == 3'd7) ? 3'd7 : streak_q + 3'd1;
                        end else begin
                            streak_d = 3'd0;
                        end
                    end else if (grant_if) begin
                        state_d    = IF_BUSY;
                        mem_en_d   = 1'b1;
                        mem_addr_d = {if_addr[31:2], 2'b00};
                        mem_be_d   = 4'h0;
                        streak_d   = 3'd0;
                    end
                end
            end
            IF_BUSY: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_en_d   = 1'b0;
                    mem_be_d   = 4'h0;
                    if_ready_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            D_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_en_d  = 1'b0;
                    mem_be_d  = 4'h0;
                    d_ready_d = 1'b1;
                    d_rdata_d = load_data;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_be_d = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            streak_q  <= 3'd0;
            byte_q    <= 1'b0;
            sext_q    <= 1'b0;
            lane_q    <= 2'd0;
            mem_en    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            byte_q    <= byte_d;
            sext_q    <= sext_d;
            lane_q    <= lane_d;
            mem_en    <= mem_en_d;
            mem_be    <= mem_be_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_ready  <= if_ready_d;
            d_ready   <= d_ready_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
        end
    end

endmodule
